// File: rtl/video_pkg.sv
// Shared types and default geometry for the video line buffer.
// Pixels travel as packed 24-bit RGB words.
package video_pkg;

    localparam int MAX_PIX_DEF = 1024;
    localparam int LINES_DEF   = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store: one write port, registered read-first read.
// No reset so it maps onto block RAM.
module line_ram
    import video_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  rgb_t          wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output rgb_t          rd_data
);

    rgb_t mem [DEPTH];
    rgb_t rd_data_q;

    // Both updates are non-blocking, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/video_line_buffer.sv
// Captures the source pixel stream into a ring of line RAMs and serves
// up-scaled pixels to the HDMI beam with a fixed 2-cycle latency.
module video_line_buffer
    import video_pkg::*;
#(
    parameter int MAX_PIX = MAX_PIX_DEF,
    parameter int LINES   = LINES_DEF,
    parameter int XSHIFT  = 1,
    parameter int YSHIFT  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_pix_en,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    input  logic        i_rd_en,
    input  logic [11:0] i_rd_x,
    input  logic [11:0] i_rd_y,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame_end,
    output logic        o_collision,
    output logic        o_overflow
);

    localparam int XW = $clog2(MAX_PIX);
    localparam int LW = $clog2(LINES);
    localparam int AW = XW + LW;

    logic          hs_q, vs_q;
    logic [XW:0]   wr_x_q, wr_x_d;
    logic [LW-1:0] wr_line_q, wr_line_d;
    logic          ovf_q, ovf_d;
    logic          fe_q, fe_d;
    logic          col_q, col_d;
    logic          blank_q, blank_d;
    rgb_t          rgb_q, rgb_d;

    logic          hs_rise, vs_rise;
    logic          wr_ok, rd_ok;
    logic [11:0]   sx, ys;
    logic [LW-1:0] sl;
    rgb_t          wr_data, rd_data;
    logic          unused_ys;

    assign hs_rise = i_hsync & ~hs_q;
    assign vs_rise = i_vsync & ~vs_q;

    // The top bit of wr_x marks a full line; further pixels are dropped.
    assign wr_ok   = i_pix_en & ~wr_x_q[XW] & reset_n;
    assign wr_data = '{r: i_r, g: i_g, b: i_b};

    assign sx        = i_rd_x >> XSHIFT;
    assign ys        = i_rd_y >> YSHIFT;
    assign sl        = ys[LW-1:0];
    assign unused_ys = ^ys[11:LW];
    assign rd_ok     = i_rd_en & ({20'd0, sx} < 32'(MAX_PIX));

    always_comb begin
        wr_x_d    = wr_x_q;
        wr_line_d = wr_line_q;
        ovf_d     = ovf_q;
        if (i_pix_en) begin
            if (!wr_x_q[XW]) begin
                wr_x_d = wr_x_q + (XW+1)'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (vs_rise) begin
            wr_line_d = '0;
            wr_x_d    = '0;
            ovf_d     = 1'b0;
        end else if (hs_rise) begin
            wr_line_d = wr_line_q + LW'(1);
            wr_x_d    = '0;
        end
        fe_d    = vs_rise;
        col_d   = i_rd_en & (sl == wr_line_q);
        blank_d = ~rd_ok;
        rgb_d   = blank_q ? '0 : rd_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            wr_x_q    <= '0;
            wr_line_q <= '0;
            ovf_q     <= 1'b0;
            fe_q      <= 1'b0;
            col_q     <= 1'b0;
            blank_q   <= 1'b1;
            rgb_q     <= '0;
        end else begin
            hs_q      <= i_hsync;
            vs_q      <= i_vsync;
            wr_x_q    <= wr_x_d;
            wr_line_q <= wr_line_d;
            ovf_q     <= ovf_d;
            fe_q      <= fe_d;
            col_q     <= col_d;
            blank_q   <= blank_d;
            rgb_q     <= rgb_d;
        end
    end

    line_ram #(
        .DEPTH(LINES * MAX_PIX),
        .AW   (AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_ok),
        .wr_addr({wr_line_q, wr_x_q[XW-1:0]}),
        .wr_data(wr_data),
        .rd_en  (rd_ok),
        .rd_addr({sl, sx[XW-1:0]}),
        .rd_data(rd_data)
    );

    assign o_r         = rgb_q.r;
    assign o_g         = rgb_q.g;
    assign o_b         = rgb_q.b;
    assign o_frame_end = fe_q;
    assign o_collision = col_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_video_line_buffer.sv
// Directed bench for video_line_buffer: vector table for the read path
// plus hand sequences for ring wrap, edges, overflow and reset.
module tb_video_line_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_pix_en, i_hsync, i_vsync;
    logic [7:0]  i_r, i_g, i_b;
    logic        i_rd_en;
    logic [11:0] i_rd_x, i_rd_y;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_frame_end, o_collision, o_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
        logic        col;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    video_line_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_pix_en   (i_pix_en),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_r        (i_r),
        .i_g        (i_g),
        .i_b        (i_b),
        .i_rd_en    (i_rd_en),
        .i_rd_x     (i_rd_x),
        .i_rd_y     (i_rd_y),
        .o_r        (o_r),
        .o_g        (o_g),
        .o_b        (o_b),
        .o_frame_end(o_frame_end),
        .o_collision(o_collision),
        .o_overflow (o_overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
        i_pix_en = 1'b1;
        i_r = r;
        i_g = g;
        i_b = b;
        tick;
        i_pix_en = 1'b0;
    endtask

    task automatic hpulse;
        i_hsync = 1'b1;
        tick;
        i_hsync = 1'b0;
        tick;
    endtask

    task automatic vpulse;
        i_vsync = 1'b1;
        tick;
        i_vsync = 1'b0;
        tick;
    endtask

    task automatic rd(input string nm, input logic en, input logic [11:0] x,
                      input logic [11:0] y, input logic [23:0] exp);
        i_rd_en = en;
        i_rd_x  = x;
        i_rd_y  = y;
        tick;
        i_rd_en = 1'b0;
        tick;
        chk(nm, {8'd0, o_r, o_g, o_b}, {8'd0, exp});
    endtask

    task automatic col_probe(input string nm, input logic [11:0] y,
                             input logic exp);
        i_rd_en = 1'b1;
        i_rd_x  = 12'd0;
        i_rd_y  = y;
        tick;
        i_rd_en = 1'b0;
        chk(nm, {31'd0, o_collision}, {31'd0, exp});
        tick;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            logic [7:0] idx;
            idx = 8'(k >> 1);
            vecs[k] = '{1'b1, 12'(k), 12'd2,
                        {idx, idx + 8'h10, idx + 8'hA0}, 1'b1};
        end
        vecs[16] = '{1'b1, 12'd2048, 12'd2, 24'd0, 1'b1};
        vecs[17] = '{1'b0, 12'd0, 12'd2, 24'd0, 1'b0};

        reset_n = 1'b0;
        i_pix_en = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
        i_r = '0; i_g = '0; i_b = '0;
        i_rd_en = 1'b0; i_rd_x = '0; i_rd_y = '0;
        tick;
        tick;
        chk("rst_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("rst_fe", {31'd0, o_frame_end}, 32'd0);
        chk("rst_col", {31'd0, o_collision}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        reset_n = 1'b1;
        tick;

        // Write 8 pixels on line 1, then stream the table reads.
        i_vsync = 1'b1;
        tick;
        chk("fe_pulse", {31'd0, o_frame_end}, 32'd1);
        i_vsync = 1'b0;
        tick;
        chk("fe_end", {31'd0, o_frame_end}, 32'd0);
        hpulse;
        for (int i = 0; i < 8; i++) begin
            pix(8'(i), 8'(i + 16), 8'(i + 8'hA0));
        end
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                i_rd_en = vecs[i].en;
                i_rd_x  = vecs[i].x;
                i_rd_y  = vecs[i].y;
            end else begin
                i_rd_en = 1'b0;
            end
            tick;
            if (i < NV) begin
                chk($sformatf("vec%0d_col", i), {31'd0, o_collision},
                    {31'd0, vecs[i].col});
            end
            if (i >= 1) begin
                chk($sformatf("vec%0d_rgb", i - 1), {8'd0, o_r, o_g, o_b},
                    {8'd0, vecs[i-1].rgb});
            end
        end

        // Ring wrap: five lines after vsync lands back on line 1.
        vpulse;
        for (int i = 0; i < 5; i++) hpulse;
        for (int i = 0; i < 4; i++) pix(8'(8'h50 + i), 8'h60, 8'h70);
        rd("wrap_x0", 1'b1, 12'd0, 12'd2, 24'h506070);
        rd("wrap_x6", 1'b1, 12'd6, 12'd3, 24'h536070);

        hpulse;
        col_probe("col_y4", 12'd4, 1'b1);
        col_probe("col_y5", 12'd5, 1'b1);
        col_probe("col_y6", 12'd6, 1'b0);

        // Simultaneous edges: vsync wins, single frame_end pulse.
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        tick;
        chk("both_fe", {31'd0, o_frame_end}, 32'd1);
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        tick;
        chk("both_fe_end", {31'd0, o_frame_end}, 32'd0);
        col_probe("both_line0", 12'd0, 1'b1);
        col_probe("both_not1", 12'd2, 1'b0);

        // Overflow: 1030 pixels into line 0.
        for (int i = 0; i < 1030; i++) begin
            pix(8'(i), 8'(i >> 8), 8'h33);
            if (i == 1023) chk("ovf_full", {31'd0, o_overflow}, 32'd0);
            if (i == 1024) chk("ovf_set", {31'd0, o_overflow}, 32'd1);
        end
        rd("ovf_last", 1'b1, 12'd2046, 12'd0, 24'hFF0333);
        rd("ovf_first", 1'b1, 12'd0, 12'd0, 24'h000033);
        rd("blank_sx", 1'b1, 12'd2048, 12'd0, 24'd0);
        rd("blank_en", 1'b0, 12'd0, 12'd0, 24'd0);
        chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        vpulse;
        chk("ovf_clr", {31'd0, o_overflow}, 32'd0);

        // Reset in the middle of a pixel burst with a read in flight.
        hpulse;
        i_rd_en = 1'b1;
        i_rd_x  = 12'd2046;
        i_rd_y  = 12'd0;
        pix(8'h11, 8'h11, 8'h11);
        pix(8'h12, 8'h12, 8'h12);
        chk("pre_rst_r", {24'd0, o_r}, 32'h0000_00FF);
        reset_n = 1'b0;
        pix(8'hEE, 8'hEE, 8'hEE);
        chk("mid_rst_rgb", {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("mid_rst_col", {31'd0, o_collision}, 32'd0);
        chk("mid_rst_fe", {31'd0, o_frame_end}, 32'd0);
        chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
        reset_n = 1'b1;
        i_rd_en = 1'b0;
        pix(8'h77, 8'h78, 8'h79);
        i_hsync = 1'b1;
        pix(8'h44, 8'h45, 8'h46);
        i_hsync = 1'b0;
        pix(8'h55, 8'h56, 8'h57);
        tick;
        rd("rst_x0", 1'b1, 12'd0, 12'd0, 24'h777879);
        rd("edge_pix", 1'b1, 12'd2, 12'd0, 24'h444546);
        rd("post_edge", 1'b1, 12'd0, 12'd2, 24'h555657);
        rd("old_x2", 1'b1, 12'd4, 12'd0, 24'h020033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
